// File: rtl/tsc_reconfig_ctrl_if.sv
// Checker-sample / host-handshake bundle between the datapath host and tsc_reconfig_ctrl.
interface tsc_reconfig_ctrl_if #(parameter int CNT_W = 8);
    logic             f;
    logic             g;
    logic             chk_valid;
    logic             clr_req;
    logic             clr_ack;
    logic             clr_ok;
    logic             logic_en;
    logic             fault_irq;
    logic [1:0]       state;
    logic [CNT_W-1:0] transient_cnt;
    logic [CNT_W-1:0] perm_cnt;

    modport master (
        output f, g, chk_valid, clr_req,
        input  clr_ack, clr_ok, logic_en, fault_irq, state, transient_cnt, perm_cnt
    );

    modport slave (
        input  f, g, chk_valid, clr_req,
        output clr_ack, clr_ok, logic_en, fault_irq, state, transient_cnt, perm_cnt
    );
endinterface

// File: rtl/tsc_reconfig_ctrl.sv
// Transient-filtering fault controller: counts consecutive two-rail checker errors,
// switches the datapath to the spare path on a permanent fault, and supports host re-test.
module tsc_reconfig_ctrl #(
    parameter int THRESH     = 3,
    parameter int RETEST_LEN = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    tsc_reconfig_ctrl_if.slave  bus
);
    localparam logic [1:0] NORMAL   = 2'd0;
    localparam logic [1:0] SUSPECT  = 2'd1;
    localparam logic [1:0] RECONFIG = 2'd2;
    localparam logic [1:0] RETEST   = 2'd3;

    localparam logic [3:0] THRESH4 = 4'(THRESH);
    localparam logic [3:0] RETEST4 = 4'(RETEST_LEN);

    logic [1:0]       state_r;
    logic [3:0]       run;
    logic             logic_en_r;
    logic             fault_irq_r;
    logic             clr_ack_r;
    logic             clr_ok_r;
    logic [CNT_W-1:0] transient_cnt_r;
    logic [CNT_W-1:0] perm_cnt_r;

    // Equal rails means the checker flagged an error.
    logic err, clean;
    assign err   = bus.chk_valid & ~(bus.f ^ bus.g);
    assign clean = bus.chk_valid &  (bus.f ^ bus.g);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= NORMAL;
            run             <= '0;
            logic_en_r      <= 1'b0;
            fault_irq_r     <= 1'b0;
            clr_ack_r       <= 1'b0;
            clr_ok_r        <= 1'b0;
            transient_cnt_r <= '0;
            perm_cnt_r      <= '0;
        end else begin
            fault_irq_r <= 1'b0;
            clr_ack_r   <= 1'b0;
            case (state_r)
                NORMAL: begin
                    if (err) begin
                        if (THRESH4 == 4'd1) begin
                            state_r     <= RECONFIG;
                            run         <= '0;
                            logic_en_r  <= 1'b1;
                            fault_irq_r <= 1'b1;
                            perm_cnt_r  <= sat_inc(perm_cnt_r);
                        end else begin
                            state_r <= SUSPECT;
                            run     <= 4'd1;
                        end
                    end
                end
                SUSPECT: begin
                    if (err) begin
                        if (run + 4'd1 == THRESH4) begin
                            state_r     <= RECONFIG;
                            run         <= '0;
                            logic_en_r  <= 1'b1;
                            fault_irq_r <= 1'b1;
                            perm_cnt_r  <= sat_inc(perm_cnt_r);
                        end else begin
                            run <= run + 4'd1;
                        end
                    end else if (clean) begin
                        state_r         <= NORMAL;
                        run             <= '0;
                        transient_cnt_r <= sat_inc(transient_cnt_r);
                    end
                end
                RECONFIG: begin
                    // Any sample coinciding with the request is dropped.
                    if (bus.clr_req) begin
                        state_r <= RETEST;
                        run     <= '0;
                    end
                end
                default: begin
                    if (clean) begin
                        if (run + 4'd1 == RETEST4) begin
                            state_r    <= NORMAL;
                            run        <= '0;
                            logic_en_r <= 1'b0;
                            clr_ack_r  <= 1'b1;
                            clr_ok_r   <= 1'b1;
                        end else begin
                            run <= run + 4'd1;
                        end
                    end else if (err) begin
                        // Failed re-test is not a new fault declaration.
                        state_r   <= RECONFIG;
                        run       <= '0;
                        clr_ack_r <= 1'b1;
                        clr_ok_r  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.state         = state_r;
    assign bus.logic_en      = logic_en_r;
    assign bus.fault_irq     = fault_irq_r;
    assign bus.clr_ack       = clr_ack_r;
    assign bus.clr_ok        = clr_ok_r;
    assign bus.transient_cnt = transient_cnt_r;
    assign bus.perm_cnt      = perm_cnt_r;
endmodule

// File: tb/tb_tsc_reconfig_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares each cycle.
module tb_tsc_reconfig_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   applied = 0;
    int   miscompares = 0;

    tsc_reconfig_ctrl_if #(.CNT_W(2)) bus();

    tsc_reconfig_ctrl #(.THRESH(3), .RETEST_LEN(4), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {state, logic_en, fault_irq, clr_ack, clr_ok, transient_cnt, perm_cnt}
    logic [9:0] exp_q[$];

    task automatic vec(input logic r, v, ff, gg, req,
                       input logic [1:0] st, input logic en, irq, ack, ok,
                       input logic [1:0] tc, pc);
        @(negedge clk);
        rst           = r;
        bus.chk_valid = v;
        bus.f         = ff;
        bus.g         = gg;
        bus.clr_req   = req;
        exp_q.push_back({st, en, irq, ack, ok, tc, pc});
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [9:0] e, a;
            e = exp_q.pop_front();
            a = {bus.state, bus.logic_en, bus.fault_irq, bus.clr_ack, bus.clr_ok,
                 bus.transient_cnt, bus.perm_cnt};
            applied++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d: got st=%0d en=%b irq=%b ack=%b ok=%b tc=%0d pc=%0d, want st=%0d en=%b irq=%b ack=%b ok=%b tc=%0d pc=%0d",
                         applied, a[9:8], a[7], a[6], a[5], a[4], a[3:2], a[1:0],
                         e[9:8], e[7], e[6], e[5], e[4], e[3:2], e[1:0]);
            end
        end
    end

    initial begin
        bus.f = 1'b0; bus.g = 1'b0; bus.chk_valid = 1'b0; bus.clr_req = 1'b0;
        // reset
        vec(1,0,0,0,0, 0,0,0,0,0, 0,0);
        vec(1,0,0,0,0, 0,0,0,0,0, 0,0);
        // 20 clean samples
        for (int i = 0; i < 20; i++) vec(0,1,0,1,0, 0,0,0,0,0, 0,0);
        // two errors then clean -> transient
        vec(0,1,0,0,0, 1,0,0,0,0, 0,0);
        vec(0,1,1,1,0, 1,0,0,0,0, 0,0);
        vec(0,1,1,0,0, 0,0,0,0,0, 1,0);
        // three errors with invalid gaps -> permanent fault
        vec(0,1,0,0,0, 1,0,0,0,0, 1,0);
        vec(0,0,0,0,0, 1,0,0,0,0, 1,0);
        vec(0,1,1,1,0, 1,0,0,0,0, 1,0);
        vec(0,0,1,0,0, 1,0,0,0,0, 1,0);
        vec(0,1,0,0,0, 2,1,1,0,0, 1,1);
        vec(0,0,0,0,0, 2,1,0,0,0, 1,1);
        for (int i = 0; i < 50; i++) vec(0,1,0,1,0, 2,1,0,0,0, 1,1);
        // successful re-test
        vec(0,0,0,1,1, 3,1,0,0,0, 1,1);
        for (int i = 0; i < 3; i++) vec(0,1,0,1,1, 3,1,0,0,0, 1,1);
        vec(0,1,1,0,1, 0,0,0,1,1, 1,1);
        vec(0,0,0,0,0, 0,0,0,0,1, 1,1);
        // second fault
        vec(0,1,0,0,0, 1,0,0,0,1, 1,1);
        vec(0,1,0,0,0, 1,0,0,0,1, 1,1);
        vec(0,1,1,1,0, 2,1,1,0,1, 1,2);
        // failed re-test; error coinciding with the request is discarded
        vec(0,1,0,0,1, 3,1,0,0,1, 1,2);
        vec(0,1,0,1,1, 3,1,0,0,1, 1,2);
        vec(0,1,0,1,1, 3,1,0,0,1, 1,2);
        vec(0,1,1,1,1, 2,1,0,1,0, 1,2);
        // request still high: new re-test starts
        vec(0,0,0,1,1, 3,1,0,0,0, 1,2);
        vec(0,1,0,1,1, 3,1,0,0,0, 1,2);
        // reset during re-test
        vec(1,1,0,0,1, 0,0,0,0,0, 0,0);
        // five transients saturate the 2-bit counter
        vec(0,1,0,0,0, 1,0,0,0,0, 0,0);
        vec(0,1,0,1,0, 0,0,0,0,0, 1,0);
        vec(0,1,1,1,0, 1,0,0,0,0, 1,0);
        vec(0,1,1,0,0, 0,0,0,0,0, 2,0);
        vec(0,1,0,0,0, 1,0,0,0,0, 2,0);
        vec(0,1,0,1,0, 0,0,0,0,0, 3,0);
        vec(0,1,0,0,0, 1,0,0,0,0, 3,0);
        vec(0,1,0,1,0, 0,0,0,0,0, 3,0);
        vec(0,1,1,1,0, 1,0,0,0,0, 3,0);
        vec(0,1,1,0,0, 0,0,0,0,0, 3,0);
        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (exp_q.size() > 0) begin
                miscompares++;
                $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/tsc_reconfig_ctrl.md
# tsc_reconfig_ctrl

Sequencing controller for the two-rail self-checking checker and the reconfiguration muxes in the fault-tolerant datapath. It samples the checker pair (f, g) and filters transient mismatches with a consecutive-error threshold. On a permanent fault it drives a sticky `logic_en` to steer the datapath onto the reconfigured (spare) path. A host request/acknowledge handshake lets the primary path be re-tested and restored.

## Interface
Parameters:
- THRESH, 3: consecutive erroneous samples that declare a permanent fault; legal range 1..15.
- RETEST_LEN, 4: consecutive clean samples required to restore the primary path; legal range 1..15.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- f  input  1  checker rail 0.
- g  input  1  checker rail 1.
- chk_valid  input  1  f/g hold a meaningful sample this cycle.
- clr_req  input  1  host request to re-test the primary path; a level signal held until clr_ack.
- clr_ack  output  1  one-cycle pulse ending a re-test.
- clr_ok  output  1  re-test result, valid while clr_ack=1 and held until the next ack. 1 = primary restored.
- logic_en  output  1  reconfiguration select to the datapath muxes. 1 = spare path.
- fault_irq  output  1  one-cycle pulse when a permanent fault is declared.
- state  output  2  NORMAL=0, SUSPECT=1, RECONFIG=2, RETEST=3.
- transient_cnt  output  CNT_W  count of filtered transient events; saturating.
- perm_cnt  output  CNT_W  count of permanent-fault declarations; saturating.

## Operation
- Error sample: err = chk_valid & ~(f ^ g), i.e. the rails are equal. Cycles with chk_valid=0 are ignored by every state and counter.
- Internal consecutive counter `run`, 4 bits.
- NORMAL (logic_en=0):
  - On err with THRESH=1: go to RECONFIG.
  - On err otherwise: go to SUSPECT with run=1.
- SUSPECT (logic_en=0):
  - On err with run+1=THRESH: go to RECONFIG.
  - On err otherwise: run++.
  - On a clean valid sample: go to NORMAL, run=0, transient_cnt++.
- Entry to RECONFIG from NORMAL or SUSPECT: fault_irq pulses and perm_cnt++.
- RECONFIG (logic_en=1, sticky):
  - Leaves only on clr_req=1. Then it goes to RETEST with run=0.
  - If chk_valid is also high in that cycle, the sample is discarded.
- RETEST (logic_en stays 1; the checker observes the primary inputs regardless of mux select):
  - On a clean valid sample with run+1=RETEST_LEN: go to NORMAL, clr_ack=1, clr_ok=1, logic_en drops to 0.
  - On a clean valid sample otherwise: run++.
  - On err: go to RECONFIG, clr_ack=1, clr_ok=0. No fault_irq, no perm_cnt increment.
- Handshake: clr_req is ignored outside RECONFIG. If the host keeps clr_req high after a failed re-test, a new RETEST starts on the next cycle. The host must drop clr_req after clr_ack.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- All outputs are registered.
- Reset values: state=NORMAL, logic_en=0, fault_irq=0, clr_ack=0, clr_ok=0, transient_cnt=0, perm_cnt=0, run=0.
- Latency: a sample present at edge N produces its state and output effect after edge N. Example: the THRESH-th consecutive error sampled at edge N gives logic_en=1 and fault_irq=1 during cycle N+1.
- fault_irq and clr_ack are high for exactly one cycle.
- Reset mid-operation (any state, including RETEST) returns to NORMAL with logic_en=0 at the next edge. It takes priority over every input, and no ack is produced.
- Non-valid cycles between samples do not break a run; only a valid sample of the opposite polarity does.

## Test plan
- Reset, then feed f=0,g=1 valid for 20 cycles: state stays 0, logic_en=0, all counters 0.
- THRESH=3, two error samples then one clean sample: state 0→1→1→0, transient_cnt=1, logic_en stays 0, no fault_irq.
- Three error samples separated by chk_valid=0 gaps: logic_en=1 one cycle after the third, one fault_irq pulse, perm_cnt=1, state=2. logic_en stays 1 for 50 further clean samples with clr_req low.
- From RECONFIG, clr_req=1 plus 4 clean samples (RETEST_LEN=4): clr_ack pulse with clr_ok=1, state=0, logic_en=0 in the same cycle.
- From RECONFIG, clr_req=1, 2 clean samples then 1 error: clr_ack with clr_ok=0, state=2, logic_en=1, perm_cnt unchanged. clr_req and chk_valid in the same cycle: that sample is ignored.
- rst asserted during RETEST: next cycle state=0, logic_en=0, counters 0, no clr_ack. With CNT_W=2, five transients: transient_cnt saturates at 3.
